// File: rtl/custom_ext_pkg.sv
// Shared encodings for the custom-0 extension: opcode, funct fields, dispatcher FSM states
// and the legality rule used by the decoder.
package custom_ext_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_SCRAMBLE = 3'b000;
    localparam logic [2:0] F3_VADD16   = 3'b001;
    localparam logic [6:0] F7_BASE     = 7'b0000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    function automatic logic is_legal(input logic [6:0] opcode,
                                      input logic [2:0] funct3,
                                      input logic [6:0] funct7);
        logic f3_ok;
        f3_ok = (funct3 == F3_SCRAMBLE) || (funct3 == F3_VADD16);
        return (opcode == OPC_CUSTOM0) && (funct7 == F7_BASE) && f3_ok;
    endfunction

endpackage

// File: rtl/custom_insn_decoder.sv
// Combinational field extraction and legality check for custom-0 instructions.
module custom_insn_decoder (
    input  logic [31:0] insn,
    output logic        legal,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);
    import custom_ext_pkg::*;

    logic [6:0] opcode_s;
    logic       unused_rs_fields_s;

    assign opcode_s = insn[6:0];
    assign rd       = insn[11:7];
    assign funct3   = insn[14:12];
    assign funct7   = insn[31:25];
    assign legal    = is_legal(opcode_s, funct3, funct7);

    // Register-specifier fields are resolved by the core; operands arrive as data.
    assign unused_rs_fields_s = ^insn[24:15];

endmodule

// File: rtl/custom_insn_dispatcher.sv
// Dispatches custom-0 instructions to an external execution unit and returns the result
// to the register file, with illegal-instruction and timeout error pulses.
module custom_insn_dispatcher
    import custom_ext_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        insn_valid,
    output logic        insn_ready,
    input  logic [31:0] insn,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        stall,
    output logic        cx_req_valid,
    input  logic        cx_req_ready,
    output logic [2:0]  cx_funct3,
    output logic [6:0]  cx_funct7,
    output logic [31:0] cx_op_a,
    output logic [31:0] cx_op_b,
    input  logic        cx_rsp_valid,
    output logic        cx_rsp_ready,
    input  logic [31:0] cx_rsp_data,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    output logic        timeout
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_r, state_next_s;
    logic        legal_s, accept_s, tmo_hit_s, ill_next_s, tmo_next_s;
    logic [4:0]  rd_s, rd_r;
    logic [2:0]  funct3_s, funct3_r;
    logic [6:0]  funct7_s, funct7_r;
    logic [15:0] cnt_r, cnt_inc_s;
    logic [31:0] op_a_r, op_b_r, wb_data_r;
    logic        insn_ready_r, stall_r, cx_req_valid_r, cx_rsp_ready_r;
    logic        wb_valid_r, illegal_r, timeout_r;

    custom_insn_decoder u_dec (
        .insn   (insn),
        .legal  (legal_s),
        .rd     (rd_s),
        .funct3 (funct3_s),
        .funct7 (funct7_s)
    );

    assign accept_s  = insn_valid & insn_ready_r & ~flush;
    assign cnt_inc_s = cnt_r + 16'd1;
    assign tmo_hit_s = (cnt_inc_s == TMO_LIMIT);

    // Next-state and error-pulse decode; a response beats a timeout landing in the same cycle.
    always_comb begin
        state_next_s = state_r;
        ill_next_s   = 1'b0;
        tmo_next_s   = 1'b0;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (legal_s) begin
                            state_next_s = ST_ISSUE;
                        end else begin
                            state_next_s = ST_ERR;
                            ill_next_s   = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (tmo_hit_s) begin
                        state_next_s = ST_ERR;
                        tmo_next_s   = 1'b1;
                    end else if (cx_req_ready) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (cx_rsp_valid) begin
                        state_next_s = ST_WB;
                    end else if (tmo_hit_s) begin
                        state_next_s = ST_ERR;
                        tmo_next_s   = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end
                ST_WB:   state_next_s = ST_IDLE;
                ST_ERR:  state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register and control outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            insn_ready_r   <= 1'b1;
            stall_r        <= 1'b0;
            cx_req_valid_r <= 1'b0;
            cx_rsp_ready_r <= 1'b0;
            wb_valid_r     <= 1'b0;
            illegal_r      <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            insn_ready_r   <= (state_next_s == ST_IDLE);
            stall_r        <= (state_next_s != ST_IDLE);
            cx_req_valid_r <= (state_next_s == ST_ISSUE);
            cx_rsp_ready_r <= (state_next_s == ST_WAIT);
            wb_valid_r     <= (state_next_s == ST_WB) && (rd_r != 5'd0);
            illegal_r      <= ill_next_s;
            timeout_r      <= tmo_next_s;
        end
    end

    // Request payload, response capture and the ISSUE+WAIT cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_r  <= 3'd0;
            funct7_r  <= 7'd0;
            rd_r      <= 5'd0;
            op_a_r    <= 32'd0;
            op_b_r    <= 32'd0;
            wb_data_r <= 32'd0;
            cnt_r     <= 16'd0;
        end else begin
            if (accept_s && legal_s) begin
                funct3_r <= funct3_s;
                funct7_r <= funct7_s;
                rd_r     <= rd_s;
                op_a_r   <= rs1_data;
                op_b_r   <= rs2_data;
            end else begin
                funct3_r <= funct3_r;
                funct7_r <= funct7_r;
                rd_r     <= rd_r;
                op_a_r   <= op_a_r;
                op_b_r   <= op_b_r;
            end
            if (accept_s) begin
                cnt_r <= 16'd0;
            end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
                cnt_r <= cnt_inc_s;
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == ST_WAIT) && cx_rsp_valid) begin
                wb_data_r <= cx_rsp_data;
            end else begin
                wb_data_r <= wb_data_r;
            end
        end
    end

    assign insn_ready   = insn_ready_r;
    assign stall        = stall_r;
    assign cx_req_valid = cx_req_valid_r;
    assign cx_rsp_ready = cx_rsp_ready_r;
    assign cx_funct3    = funct3_r;
    assign cx_funct7    = funct7_r;
    assign cx_op_a      = op_a_r;
    assign cx_op_b      = op_b_r;
    assign wb_rd        = rd_r;
    assign wb_data      = wb_data_r;
    // Flush cancels pulses already scheduled for this cycle, including a pending writeback.
    assign wb_valid     = wb_valid_r & ~flush;
    assign illegal      = illegal_r & ~flush;
    assign timeout      = timeout_r & ~flush;

endmodule

// File: tb/tb_custom_insn_dispatcher.sv
// Self-checking bench: legality table, directed multi-cycle corner cases and randomized
// transactions against a transaction-level latency/outcome model for two timeout settings.
module tb_custom_insn_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n, insn_valid, flush, cx_req_ready, cx_rsp_valid;
    logic [31:0] insn, rs1_data, rs2_data, cx_rsp_data;

    logic        d_insn_ready, d_stall, d_cx_req_valid, d_cx_rsp_ready, d_wb_valid, d_illegal, d_timeout;
    logic [2:0]  d_cx_funct3;
    logic [6:0]  d_cx_funct7;
    logic [31:0] d_cx_op_a, d_cx_op_b, d_wb_data;
    logic [4:0]  d_wb_rd;
    logic        t_insn_ready, t_stall, t_cx_req_valid, t_cx_rsp_ready, t_wb_valid, t_illegal, t_timeout;
    logic [2:0]  t_cx_funct3;
    logic [6:0]  t_cx_funct7;
    logic [31:0] t_cx_op_a, t_cx_op_b, t_wb_data;
    logic [4:0]  t_wb_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    custom_insn_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .insn_valid(insn_valid), .insn_ready(d_insn_ready), .insn(insn),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .stall(d_stall),
        .cx_req_valid(d_cx_req_valid), .cx_req_ready(cx_req_ready), .cx_funct3(d_cx_funct3),
        .cx_funct7(d_cx_funct7), .cx_op_a(d_cx_op_a), .cx_op_b(d_cx_op_b),
        .cx_rsp_valid(cx_rsp_valid), .cx_rsp_ready(d_cx_rsp_ready), .cx_rsp_data(cx_rsp_data),
        .wb_valid(d_wb_valid), .wb_rd(d_wb_rd), .wb_data(d_wb_data),
        .illegal(d_illegal), .timeout(d_timeout)
    );

    custom_insn_dispatcher #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .insn_valid(insn_valid), .insn_ready(t_insn_ready), .insn(insn),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .stall(t_stall),
        .cx_req_valid(t_cx_req_valid), .cx_req_ready(cx_req_ready), .cx_funct3(t_cx_funct3),
        .cx_funct7(t_cx_funct7), .cx_op_a(t_cx_op_a), .cx_op_b(t_cx_op_b),
        .cx_rsp_valid(cx_rsp_valid), .cx_rsp_ready(t_cx_rsp_ready), .cx_rsp_data(cx_rsp_data),
        .wb_valid(t_wb_valid), .wb_rd(t_wb_rd), .wb_data(t_wb_data),
        .illegal(t_illegal), .timeout(t_timeout)
    );

    localparam logic [127:0] RESET_PAT = {10'd0, 1'b1, 117'd0};

    typedef struct {
        logic [31:0] insn;
        logic        exp_legal;
        logic        exp_wb;
    } vec_t;
    vec_t vecs[8];

    // Observation slots: 0..2 = dut wb/illegal/timeout, 3..5 = dut_t wb/illegal/timeout.
    int          obs_off[6];
    int          obs_cnt[6];
    logic [31:0] obs_data[2];
    logic [4:0]  obs_rd[2];
    int          req_cnt, rsp_rdy_cnt;
    logic        stable;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_d();
        return {10'd0, d_insn_ready, d_stall, d_cx_req_valid, d_cx_funct3, d_cx_funct7, d_cx_op_a,
                d_cx_op_b, d_cx_rsp_ready, d_wb_valid, d_wb_rd, d_wb_data, d_illegal, d_timeout};
    endfunction

    function automatic logic [127:0] pack_t();
        return {10'd0, t_insn_ready, t_stall, t_cx_req_valid, t_cx_funct3, t_cx_funct7, t_cx_op_a,
                t_cx_op_b, t_cx_rsp_ready, t_wb_valid, t_wb_rd, t_wb_data, t_illegal, t_timeout};
    endfunction

    function automatic logic ref_legal(input logic [31:0] w);
        logic [31:0] v;
        v = w;
        return (v[6:0] == 7'b0001011) && (v[31:25] == 7'd0) && (v[14:12] <= 3'd1);
    endfunction

    // Outcome of one transaction as offsets from the accept cycle (-1 = never).
    task automatic predict(input int lim, input logic legal, input logic [4:0] rd, input int dq,
                           input int dr, output int wb, output int ill, output int tmo);
        wb = -1; ill = -1; tmo = -1;
        if (!legal) ill = 1;
        else if (dq + 1 >= lim) tmo = lim + 1;
        else if (dq + dr + 2 <= lim) begin
            if (rd != 5'd0) wb = dq + dr + 3;
        end else tmo = lim + 1;
    endtask

    task automatic idle_inputs();
        insn_valid = 1'b0; insn = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0;
        cx_req_ready = 1'b0; cx_rsp_valid = 1'b0; cx_rsp_data = 32'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 6; i++) begin obs_off[i] = -1; obs_cnt[i] = 0; end
        obs_data[0] = 32'd0; obs_data[1] = 32'd0; obs_rd[0] = 5'd0; obs_rd[1] = 5'd0;
        req_cnt = 0; rsp_rdy_cnt = 0;
    endtask

    task automatic note(input int idx, input int o, input logic v);
        if (v) begin
            if (obs_cnt[idx] == 0) obs_off[idx] = o;
            obs_cnt[idx]++;
        end
    endtask

    task automatic sample_all(input int o);
        note(0, o, d_wb_valid); note(1, o, d_illegal); note(2, o, d_timeout);
        note(3, o, t_wb_valid); note(4, o, t_illegal); note(5, o, t_timeout);
        if (d_wb_valid) begin obs_data[0] = d_wb_data; obs_rd[0] = d_wb_rd; end
        if (t_wb_valid) begin obs_data[1] = t_wb_data; obs_rd[1] = t_wb_rd; end
        if (d_cx_req_valid) req_cnt++;
        if (d_cx_rsp_ready) rsp_rdy_cnt++;
    endtask

    task automatic accept(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        cyc();
        insn_valid = 1'b1; insn = w; rs1_data = a; rs2_data = b;
        settle();
    endtask

    logic [31:0] w, rdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    int          dq, dr, e_wb, e_ill, e_tmo, lim, b;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        vecs[0] = '{32'h0000008B, 1'b1, 1'b1};
        vecs[1] = '{{7'h00, 10'h155, 3'b001, 5'd7, 7'h0B}, 1'b1, 1'b1};
        vecs[2] = '{{7'h00, 10'h000, 3'b010, 5'd2, 7'h0B}, 1'b0, 1'b0};
        vecs[3] = '{{7'h01, 10'h000, 3'b000, 5'd3, 7'h0B}, 1'b0, 1'b0};
        vecs[4] = '{{7'h00, 10'h000, 3'b000, 5'd4, 7'h2B}, 1'b0, 1'b0};
        vecs[5] = '{{7'h00, 10'h3FF, 3'b111, 5'd5, 7'h0B}, 1'b0, 1'b0};
        vecs[6] = '{{7'h00, 10'h0AA, 3'b001, 5'd0, 7'h0B}, 1'b1, 1'b0};
        vecs[7] = '{{7'h40, 10'h000, 3'b001, 5'd9, 7'h0B}, 1'b0, 1'b0};

        #12;
        check("reset_outputs", pack_d(), RESET_PAT);
        check("reset_outputs_t", pack_t(), RESET_PAT);
        cyc(); rst_n = 1'b1;
        cyc();

        // Basic scramble transaction at minimum latency.
        accept(32'h0000008B, 32'h0000FFFF, 32'h12345678);
        check("acc_insn_ready", d_insn_ready, 1'b1);
        cyc(); insn_valid = 1'b0; cx_req_ready = 1'b1; settle();
        check("n1_req", {d_cx_req_valid, d_stall, d_insn_ready, d_cx_funct3, d_cx_funct7},
              {1'b1, 1'b1, 1'b0, 3'd0, 7'd0});
        check("n1_ops", {d_cx_op_a, d_cx_op_b}, {32'h0000FFFF, 32'h12345678});
        cyc(); cx_req_ready = 1'b0; cx_rsp_valid = 1'b1; cx_rsp_data = 32'hEDCB5678; settle();
        check("n2_rsp_ready", {d_cx_rsp_ready, d_cx_req_valid, d_wb_valid}, {1'b1, 1'b0, 1'b0});
        cyc(); cx_rsp_valid = 1'b0; settle();
        check("n3_wb", {d_wb_valid, d_wb_rd, d_wb_data}, {1'b1, 5'd1, 32'hEDCB5678});
        cyc(); settle();
        check("n4_idle", {d_wb_valid, d_insn_ready, d_stall}, {1'b0, 1'b1, 1'b0});

        // Legality table.
        for (int i = 0; i < 8; i++) begin
            logic rdy2;
            idle_inputs();
            accept(vecs[i].insn, 32'hA5A50000 + i, 32'h0F0F0000 + i);
            cx_req_ready = 1'b1; cx_rsp_valid = 1'b1; cx_rsp_data = 32'h1000 + i;
            clear_obs();
            rdy2 = 1'b0;
            for (int o = 1; o <= 5; o++) begin
                cyc(); insn_valid = 1'b0; settle();
                sample_all(o);
                if (o == 2) rdy2 = d_insn_ready;
            end
            check($sformatf("vec%0d_illegal_cnt", i), obs_cnt[1], vecs[i].exp_legal ? 0 : 1);
            check($sformatf("vec%0d_req_cycles", i), req_cnt, vecs[i].exp_legal ? 1 : 0);
            check($sformatf("vec%0d_wb_cnt", i), obs_cnt[0], vecs[i].exp_wb ? 1 : 0);
            check($sformatf("vec%0d_ready_at_n2", i), rdy2, !vecs[i].exp_legal);
            if (vecs[i].exp_legal)
                check($sformatf("vec%0d_rsp_ready_cycles", i), rsp_rdy_cnt, 1);
        end
        idle_inputs();

        // Unit not ready for 5 cycles: request and payload must hold.
        accept({7'h00, 10'h0, 3'b001, 5'd5, 7'h0B}, 32'hCAFEF00D, 32'h0BADBEEF);
        stable = 1'b1;
        clear_obs();
        for (int o = 1; o <= 9; o++) begin
            cyc(); insn_valid = 1'b0;
            cx_req_ready = (o == 6); cx_rsp_valid = (o == 7); cx_rsp_data = 32'h00C0FFEE;
            settle();
            sample_all(o);
            if (o <= 5 && !(d_cx_req_valid && d_stall && d_cx_op_a == 32'hCAFEF00D &&
                            d_cx_op_b == 32'h0BADBEEF && d_cx_funct3 == 3'd1))
                stable = 1'b0;
        end
        check("stall5_stable", stable, 1'b1);
        check("stall5_wb", {obs_off[0], obs_rd[0], obs_data[0]}, {32'd8, 5'd5, 32'h00C0FFEE});
        idle_inputs();

        // Timeout with limit 4 and no activity from the unit.
        accept({7'h00, 10'h0, 3'b000, 5'd6, 7'h0B}, 32'd1, 32'd2);
        clear_obs();
        req_cnt = 0;
        for (int o = 1; o <= 8; o++) begin
            cyc(); insn_valid = 1'b0; settle();
            sample_all(o);
            if (o == 6) check("tmo_ready_back", t_insn_ready, 1'b1);
        end
        check("tmo_pulse", {obs_off[5], obs_cnt[5]}, {32'd5, 32'd1});
        check("tmo_no_wb", obs_cnt[3], 0);
        check("tmo_default_quiet", obs_cnt[2], 0);
        cyc(); flush = 1'b1; settle();
        cyc(); flush = 1'b0; settle();
        check("flush_from_issue", {d_insn_ready, d_stall, d_cx_req_valid}, {1'b1, 1'b0, 1'b0});

        // Response on the same cycle the limit is reached wins.
        accept({7'h00, 10'h0, 3'b001, 5'd12, 7'h0B}, 32'd3, 32'd4);
        clear_obs();
        for (int o = 1; o <= 7; o++) begin
            cyc(); insn_valid = 1'b0;
            cx_req_ready = (o == 1); cx_rsp_valid = (o == 4); cx_rsp_data = 32'h5A5A1234;
            settle();
            sample_all(o);
        end
        check("prec_wb", {obs_off[3], obs_rd[1], obs_data[1]}, {32'd5, 5'd12, 32'h5A5A1234});
        check("prec_no_tmo", obs_cnt[5], 0);
        idle_inputs();

        // Flush in WAIT together with a response.
        accept({7'h00, 10'h0, 3'b000, 5'd3, 7'h0B}, 32'd5, 32'd6);
        clear_obs();
        for (int o = 1; o <= 6; o++) begin
            cyc(); insn_valid = 1'b0;
            cx_req_ready = (o == 1); cx_rsp_valid = (o == 2); flush = (o == 2);
            cx_rsp_data = 32'h77777777;
            settle();
            sample_all(o);
            if (o == 3) check("flush_wait_idle", {d_insn_ready, d_stall}, {1'b1, 1'b0});
        end
        check("flush_wait_no_wb", obs_cnt[0] + obs_cnt[3], 0);
        idle_inputs();

        // Flush during WB cancels the writeback of that cycle.
        accept({7'h00, 10'h0, 3'b000, 5'd4, 7'h0B}, 32'd7, 32'd8);
        cyc(); insn_valid = 1'b0; cx_req_ready = 1'b1; settle();
        cyc(); cx_req_ready = 1'b0; cx_rsp_valid = 1'b1; settle();
        cyc(); cx_rsp_valid = 1'b0; flush = 1'b1; settle();
        check("flush_wb_cancel", {d_wb_valid, t_wb_valid}, {1'b0, 1'b0});
        cyc(); flush = 1'b0; settle();
        check("flush_wb_idle", {d_insn_ready, d_wb_valid}, {1'b1, 1'b0});

        // Flush beats acceptance in IDLE.
        accept({7'h00, 10'h0, 3'b000, 5'd4, 7'h0B}, 32'd9, 32'd10);
        flush = 1'b1;
        cyc(); insn_valid = 1'b0; flush = 1'b0; settle();
        check("flush_no_accept", {d_stall, d_cx_req_valid, d_insn_ready}, {1'b0, 1'b0, 1'b1});

        // Asynchronous reset mid-ISSUE abandons the request.
        accept({7'h00, 10'h0, 3'b000, 5'd8, 7'h0B}, 32'hDEAD0001, 32'hDEAD0002);
        cyc(); insn_valid = 1'b0; settle();
        check("pre_reset_issue", d_cx_req_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset", pack_d(), RESET_PAT);
        cyc(); cyc();
        rst_n = 1'b1;
        clear_obs();
        for (int o = 1; o <= 5; o++) begin
            cyc(); cx_req_ready = 1'b1; cx_rsp_valid = 1'b1; cx_rsp_data = 32'h99999999; settle();
            sample_all(o);
        end
        check("post_reset_quiet", {obs_cnt[0], obs_cnt[1], obs_cnt[2], req_cnt}, 128'd0);
        check("post_reset_outputs", pack_d(), RESET_PAT);
        idle_inputs();

        // Randomized transactions against the outcome model, both timeout settings.
        for (int n = 0; n < 40; n++) begin
            rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
            f3 = 3'($urandom_range(1)); f7 = 7'd0; opc = 7'h0B;
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(2))
                    0: begin opc = 7'($urandom_range(127)); if (opc == 7'h0B) opc = 7'h2B; end
                    1: f3 = 3'(2 + $urandom_range(5));
                    default: f7 = 7'(1 + $urandom_range(126));
                endcase
            end
            w = {f7, 10'($urandom), f3, rd, opc};
            dq = $urandom_range(4); dr = $urandom_range(4); rdata = $urandom;
            clear_obs();
            for (int o = 0; o <= 14; o++) begin
                cyc();
                insn_valid = (o == 0); insn = w; rs1_data = $urandom; rs2_data = $urandom;
                cx_req_ready = (o >= 1 + dq);
                if (o == dq + 2 + dr) begin cx_rsp_valid = 1'b1; cx_rsp_data = rdata; end
                else begin
                    cx_rsp_valid = (o < dq + 2) ? 1'($urandom_range(1)) : 1'b0;
                    cx_rsp_data = $urandom;
                end
                settle();
                if (o >= 1) sample_all(o);
            end
            for (int k = 0; k < 2; k++) begin
                lim = (k == 0) ? 255 : 4;
                b = 3 * k;
                predict(lim, ref_legal(w), rd, dq, dr, e_wb, e_ill, e_tmo);
                check($sformatf("rnd%0d_t%0d_wb_off", n, lim), obs_off[b], e_wb);
                check($sformatf("rnd%0d_t%0d_wb_cnt", n, lim), obs_cnt[b], (e_wb >= 0) ? 1 : 0);
                check($sformatf("rnd%0d_t%0d_ill", n, lim), {obs_off[b+1], obs_cnt[b+1]},
                      {e_ill, (e_ill >= 0) ? 32'd1 : 32'd0});
                check($sformatf("rnd%0d_t%0d_tmo", n, lim), {obs_off[b+2], obs_cnt[b+2]},
                      {e_tmo, (e_tmo >= 0) ? 32'd1 : 32'd0});
                if (e_wb >= 0)
                    check($sformatf("rnd%0d_t%0d_wb_payload", n, lim), {obs_rd[k], obs_data[k]},
                          {rd, rdata});
            end
            idle_inputs();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/custom_insn_dispatcher.md
CUSTOM_INSN_DISPATCHER -- requirements
Module: custom_insn_dispatcher

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent in ISSUE+WAIT before abort (range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports insn_valid input 1, insn_ready output 1, insn input 32: core-to-dispatcher instruction handshake.
REQ-005 SHALL have ports rs1_data input 32 and rs2_data input 32: operand values, sampled with insn.
REQ-006 SHALL have port flush  input  1  cancels any in-flight instruction.
REQ-007 SHALL have port stall  output  1  holds the core pipeline while busy.
REQ-008 SHALL have ports cx_req_valid output 1, cx_req_ready input 1, cx_funct3 output 3, cx_funct7 output 7, cx_op_a output 32, cx_op_b output 32: request to the custom execution unit.
REQ-009 SHALL have ports cx_rsp_valid input 1, cx_rsp_ready output 1, cx_rsp_data input 32: response from the custom execution unit.
REQ-010 SHALL have ports wb_valid output 1, wb_rd output 5, wb_data output 32: register-file writeback.
REQ-011 SHALL have ports illegal output 1 and timeout output 1: single-cycle error pulses.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, WB, ERR.
REQ-013 SHALL drive insn_ready=1 only in IDLE; the transfer is insn_valid&insn_ready.
REQ-014 SHALL decode opcode=insn[6:0], rd=insn[11:7], funct3=insn[14:12], funct7=insn[31:25].
REQ-015 SHALL treat an instruction as legal only if opcode=7'b0001011 (custom-0), funct7=7'b0000000, and funct3 is in {3'b000 scramble, 3'b001 dual-16-bit add}.
REQ-016 SHALL, on an accepted legal instruction, register funct3, funct7, rs1_data, rs2_data and rd, then go to ISSUE.
REQ-017 SHALL, on an accepted illegal instruction, go to ERR, pulse illegal for exactly one cycle there, and return to IDLE; no request and no writeback.
REQ-018 SHALL hold cx_req_valid=1 in ISSUE with a stable payload until cx_req_ready=1, then go to WAIT.
REQ-019 SHALL drive cx_rsp_ready=1 only in WAIT; cx_rsp_valid outside WAIT is ignored.
REQ-020 SHALL, in WAIT on cx_rsp_valid=1, capture cx_rsp_data into wb_data and go to WB.
REQ-021 SHALL, in WB, assert wb_valid for exactly one cycle with the registered rd, unless rd=0 (wb_valid stays 0), then return to IDLE.
REQ-022 SHALL give minimum latency accept@N, cx_req_valid@N+1, wb_valid@N+3 (ready at N+1, response at N+2).
REQ-023 SHALL count cycles in ISSUE+WAIT with a 16-bit counter cleared on accept; reaching TIMEOUT_CYCLES moves to ERR with a one-cycle timeout pulse and no writeback.
REQ-024 SHALL have response-versus-timeout precedence such that a response in the same cycle the counter reaches TIMEOUT_CYCLES wins (normal WB, no timeout).
REQ-025 SHALL, on flush=1 in any state, go to IDLE next cycle and suppress wb_valid, illegal and timeout; a flush in WB cancels the pending writeback.
REQ-026 SHALL make flush take precedence over insn acceptance in the same cycle (nothing accepted).
REQ-027 SHALL drive stall=1 whenever state is not IDLE.

Reset
REQ-028 SHALL, on rst_n=0 (asynchronous), enter IDLE immediately with every output except insn_ready at 0, insn_ready=1, and the counter at 0.
REQ-029 SHALL abandon any in-flight request on reset mid-operation, with no writeback or error pulse after release.

Structure
REQ-030 SHALL place the CUSTOM0 opcode constant, the funct3 encodings (SCRAMBLE=000, VADD16=001) and the FSM state enum in a shared package custom_ext_pkg.
REQ-031 SHALL place the legality decode in one combinational sub-module custom_insn_decoder (insn in, legal/rd/funct3/funct7 out).

Verification
REQ-032 SHALL have a bench case: insn 0x0000008B (custom-0, f3=000, rd=1) with rs1=0x0000FFFF, rs2=0x12345678, unit ready immediately, response 0xEDCB5678 next cycle -> wb_valid@N+3, wb_rd=1, wb_data=0xEDCB5678.
REQ-033 SHALL have a bench case: insn with f3=3'b010 or funct7=7'b0000001 -> illegal pulses 1 cycle, cx_req_valid and wb_valid never asserted, insn_ready back to 1 two cycles after accept.
REQ-034 SHALL have a bench case: cx_req_ready held low 5 cycles -> cx_req_valid and payload stable all 5 cycles, stall=1 throughout.
REQ-035 SHALL have a bench case: TIMEOUT_CYCLES=4, no response -> timeout pulses once, wb_valid stays 0, state returns to IDLE.
REQ-036 SHALL have a bench case: legal insn with rd=0 -> full request/response handshake, wb_valid stays 0.
REQ-037 SHALL have a bench case: flush asserted in WAIT with response in the same cycle, then rst_n pulsed low mid-ISSUE -> no writeback, all outputs at reset values.
